// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its dcache load
// response, aligns/extends the load data and hands the result to write-back.
module mem_stage #(
    parameter int SIDE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              em_valid_i,
    output logic              mem_allowin_o,
    input  logic [31:0]       em_pc_i,
    input  logic              em_load_i,
    input  logic [2:0]        em_load_op_i,
    input  logic [1:0]        em_addr_lo_i,
    input  logic              em_req_sent_i,
    input  logic              em_excep_i,
    input  logic [31:0]       em_regs_wdata_i,
    input  logic [SIDE_W-1:0] em_side_i,
    input  logic              dcache_data_ok_i,
    input  logic [31:0]       dcache_rdata_i,
    input  logic              wb_allowin_i,
    input  logic              wb_flush_i,
    output logic              mw_valid_o,
    output logic [31:0]       mw_pc_o,
    output logic [31:0]       mw_regs_wdata_o,
    output logic [SIDE_W-1:0] mw_side_o
);

    logic              valid_q, valid_d;
    logic              buf_valid_q, buf_valid_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic [1:0]        cancel_cnt_q, cancel_cnt_d;

    logic [31:0]       pc_q;
    logic              load_q;
    logic [2:0]        op_q;
    logic [1:0]        addr_lo_q;
    logic              req_sent_q;
    logic              excep_q;
    logic [31:0]       regs_wdata_q;
    logic [SIDE_W-1:0] side_q;

    logic              wait_resp;
    logic              resp_mine;
    logic              ready_go;
    logic              accept;
    logic [31:0]       raw_data;
    logic [31:0]       shifted;
    logic [31:0]       aligned;
    logic [1:0]        cancel_inc;
    logic              cancel_dec;
    logic [2:0]        cancel_sum;

    always_comb begin
        wait_resp     = valid_q & load_q & req_sent_q & ~excep_q & ~buf_valid_q;
        resp_mine     = dcache_data_ok_i & (cancel_cnt_q == 2'd0);
        ready_go      = ~wait_resp | resp_mine;
        mem_allowin_o = ~valid_q | (ready_go & wb_allowin_i);
        mw_valid_o    = valid_q & ready_go;
        accept        = mem_allowin_o & ~wb_flush_i;
    end

    // A response captured while write-back stalls takes precedence over the live bus.
    always_comb begin
        raw_data = buf_valid_q ? buf_data_q : dcache_rdata_i;
        shifted  = raw_data >> {addr_lo_q, 3'b000};
        case (op_q)
            3'b000:  aligned = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  aligned = {24'h0, shifted[7:0]};
            3'b001:  aligned = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  aligned = {16'h0, shifted[15:0]};
            default: aligned = shifted;
        endcase
        mw_regs_wdata_o = (load_q & ~excep_q) ? aligned : regs_wdata_q;
        mw_pc_o         = pc_q;
        mw_side_o       = side_q;
    end

    always_comb begin
        valid_d     = valid_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (wb_flush_i) begin
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = em_valid_i;
            buf_valid_d = 1'b0;
        end else if (resp_mine & wait_resp & ~wb_allowin_i) begin
            buf_valid_d = 1'b1;
            buf_data_d  = dcache_rdata_i;
        end
    end

    // Count responses still owed to loads killed by a flush: the one we were waiting
    // on, plus one already issued by execute but not yet accepted here.
    always_comb begin
        cancel_inc = 2'd0;
        if (wb_flush_i) begin
            cancel_inc = {1'b0, wait_resp & ~resp_mine}
                       + {1'b0, em_valid_i & em_req_sent_i & ~em_excep_i & em_load_i};
        end
        cancel_dec   = dcache_data_ok_i & (cancel_cnt_q != 2'd0);
        cancel_sum   = {1'b0, cancel_cnt_q} + {1'b0, cancel_inc} - {2'b00, cancel_dec};
        cancel_cnt_d = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            cancel_cnt_q <= 2'd0;
        end else begin
            valid_q      <= valid_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            load_q       <= 1'b0;
            op_q         <= '0;
            addr_lo_q    <= '0;
            req_sent_q   <= 1'b0;
            excep_q      <= 1'b0;
            regs_wdata_q <= '0;
            side_q       <= '0;
        end else if (accept) begin
            pc_q         <= em_pc_i;
            load_q       <= em_load_i;
            op_q         <= em_load_op_i;
            addr_lo_q    <= em_addr_lo_i;
            req_sent_q   <= em_req_sent_i;
            excep_q      <= em_excep_i;
            regs_wdata_q <= em_regs_wdata_i;
            side_q       <= em_side_i;
        end
    end

endmodule
